// File: rtl/rom_arbiter_pkg.sv
// rtl/rom_arbiter_pkg.sv - shared ROM types, requester enum and address helpers
package rom_arbiter_pkg;

  localparam int WORD_SIZE           = 32;
  localparam int WORD_ADDRESS_SIZE   = 2;   // byte-offset bits inside a word
  localparam int ROM_ADDRESS_SIZE    = 16;  // byte address width seen by the pipeline
  localparam int ROM_WORD_INDEX_SIZE = 6;   // rom holds 64 words; upper address bits wrap

  typedef logic [WORD_SIZE-1:0]           Word;
  typedef logic [ROM_ADDRESS_SIZE-1:0]    RomAddress;
  typedef logic [ROM_WORD_INDEX_SIZE-1:0] RomWordIndex;

  typedef enum logic {ROM_REQ_FETCH, ROM_REQ_LOAD} RomRequester;

  // Word index exactly as rom truncates a byte address.
  function automatic RomWordIndex word_address(input RomAddress addr);
    return addr[WORD_ADDRESS_SIZE +: ROM_WORD_INDEX_SIZE];
  endfunction

  function automatic logic misaligned(input RomAddress addr);
    return addr[WORD_ADDRESS_SIZE-1:0] != '0;
  endfunction

endpackage

// File: rtl/rom_arbiter_pick.sv
// rtl/rom_arbiter_pick.sv - combinational winner selection for the rom arbiter
module rom_arb_pick
  import rom_arbiter_pkg::*;
#(
  parameter int FETCH_MAX_CONSEC = 4
) (
  input  logic        if_req,
  input  logic        ld_req,
  input  logic [3:0]  consec,
  output RomRequester winner,
  output logic        valid
);

  // Fetch wins ties until it has used up its consecutive contested budget.
  always_comb begin
    valid  = if_req | ld_req;
    winner = ROM_REQ_FETCH;
    if (ld_req && (!if_req || consec == 4'(FETCH_MAX_CONSEC))) begin
      winner = ROM_REQ_LOAD;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - weighted fetch/load arbiter for the single rom read port (option: ROM_ARBITER_ALIGN_CHECK_EN)
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int FETCH_MAX_CONSEC = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      if_req,
  input  RomAddress if_addr,
  output logic      if_gnt,
  output logic      if_rvalid,
  output Word       if_rdata,
  output logic      if_err,
  input  logic      ld_req,
  input  RomAddress ld_addr,
  output logic      ld_gnt,
  output logic      ld_rvalid,
  output Word       ld_rdata,
  output logic      ld_err,
  output RomAddress rom_address,
  input  Word       rom_out
);

  logic [3:0]  consec;
  RomRequester winner;
  logic        pick_valid;
  Word         resp_data;

  rom_arb_pick #(
    .FETCH_MAX_CONSEC(FETCH_MAX_CONSEC)
  ) u_pick (
    .if_req (if_req),
    .ld_req (ld_req),
    .consec (consec),
    .winner (winner),
    .valid  (pick_valid)
  );

  // Grants and the shared rom address; nothing is granted while reset is held.
  always_comb begin
    if_gnt      = rst_n & pick_valid & (winner == ROM_REQ_FETCH);
    ld_gnt      = rst_n & pick_valid & (winner == ROM_REQ_LOAD);
    rom_address = '0;
    if (if_gnt) begin
      rom_address = if_addr;
    end else if (ld_gnt) begin
      rom_address = ld_addr;
    end
  end

`ifdef ROM_ARBITER_ALIGN_CHECK_EN
  logic resp_err;

  // Misaligned grants still consume the slot but return zero data with err.
  always_comb begin
    resp_data = rom_out;
    resp_err  = 1'b0;
    if (misaligned(rom_address)) begin
      resp_data = '0;
      resp_err  = 1'b1;
    end
  end

  // Error flags travel with the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_err <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      if_err <= if_gnt & resp_err;
      ld_err <= ld_gnt & resp_err;
    end
  end

`ifndef SYNTHESIS
  // Simulation trace of misaligned rom accesses.
  always @(posedge clk) begin
    if (rst_n && resp_err && (if_gnt || ld_gnt)) begin
      $display("rom_arbiter: warning misaligned %s address %h",
               if_gnt ? "fetch" : "load", rom_address);
    end
  end
`endif
`else
  // Low address bits are simply dropped by rom, so the aligned word comes back.
  always_comb begin
    resp_data = rom_out;
  end

  assign if_err = 1'b0;
  assign ld_err = 1'b0;
`endif

  // Contested-win counter: clears on any load grant, saturates at the budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consec <= '0;
    end else if (ld_gnt) begin
      consec <= '0;
    end else if (if_gnt && ld_req && consec < 4'(FETCH_MAX_CONSEC)) begin
      consec <= consec + 4'd1;
    end
  end

  // Response stage: one-cycle registered data, rdata holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
      if_rdata  <= '0;
      ld_rdata  <= '0;
    end else begin
      if_rvalid <= if_gnt;
      ld_rvalid <= ld_gnt;
      if (if_gnt) begin
        if_rdata <= resp_data;
      end
      if (ld_gnt) begin
        ld_rdata <= resp_data;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      if_req, ld_req;
  RomAddress if_addr, ld_addr;
  logic      if_gnt, if_rvalid, if_err;
  logic      ld_gnt, ld_rvalid, ld_err;
  Word       if_rdata, ld_rdata;
  RomAddress rom_address;
  Word       rom_out;

  int n_cmp = 0;
  int n_bad = 0;

  rom_arbiter #(.FETCH_MAX_CONSEC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .rom_address(rom_address), .rom_out(rom_out)
  );

  always #5 clk = ~clk;

  function automatic Word memv(input int i);
    return {8'hA5, 8'(i), 8'h5A, 8'(~i)};
  endfunction

  // rom model: combinational read, word index truncated like rom
  always_comb rom_out = memv(int'(word_address(rom_address)));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 0);
    chk({tag, "_ld_gnt"}, 32'(ld_gnt), 0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 0);
    chk({tag, "_ld_rvalid"}, 32'(ld_rvalid), 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_ld_rdata"}, ld_rdata, 0);
    chk({tag, "_if_err"}, 32'(if_err), 0);
    chk({tag, "_ld_err"}, 32'(ld_err), 0);
    chk({tag, "_rom_address"}, 32'(rom_address), 0);
    chk({tag, "_consec"}, 32'(dut.consec), 0);
  endtask

  // Requesters must hold addr while req is pending without a grant.
  logic      p_if_req = 1'b0, p_if_gnt = 1'b0, p_ld_req = 1'b0, p_ld_gnt = 1'b0;
  RomAddress p_if_addr = '0, p_ld_addr = '0;
  always @(posedge clk) begin
    if (rst_n && p_if_req && !p_if_gnt && if_req) chk("if_addr_stable", 32'(if_addr), 32'(p_if_addr));
    if (rst_n && p_ld_req && !p_ld_gnt && ld_req) chk("ld_addr_stable", 32'(ld_addr), 32'(p_ld_addr));
    p_if_req = if_req; p_if_gnt = if_gnt; p_if_addr = if_addr;
    p_ld_req = ld_req; p_ld_gnt = ld_gnt; p_ld_addr = ld_addr;
  end

  initial begin
    int nf, nl;
    logic exp_l;
    rst_n = 1'b0; if_req = 1'b0; ld_req = 1'b0; if_addr = '0; ld_addr = '0;
    #2;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // fetch only, addresses 0, 4, 8
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = RomAddress'(4 * i);
      #1;
      chk("fo_if_gnt", 32'(if_gnt), 1);
      chk("fo_ld_gnt", 32'(ld_gnt), 0);
      chk("fo_rom_address", 32'(rom_address), 32'(4 * i));
      @(posedge clk); #1;
      chk("fo_if_rvalid", 32'(if_rvalid), 1);
      chk("fo_if_rdata", if_rdata, memv(i));
      chk("fo_ld_rvalid", 32'(ld_rvalid), 0);
      chk("fo_consec", 32'(dut.consec), 0);
    end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("idle_if_gnt", 32'(if_gnt), 0);
    chk("idle_rom_address", 32'(rom_address), 0);
    @(posedge clk); #1;
    chk("idle_if_rvalid", 32'(if_rvalid), 0);
    chk("idle_if_rdata_hold", if_rdata, memv(2));

    // both requesting: F,F,F,F,L repeating
    nf = 0; nl = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = RomAddress'(4 * nf);
      ld_req = 1'b1; ld_addr = RomAddress'(16'h40 + 4 * nl);
      exp_l = (k % 5 == 4);
      #1;
      chk("ct_if_gnt", 32'(if_gnt), 32'(!exp_l));
      chk("ct_ld_gnt", 32'(ld_gnt), 32'(exp_l));
      chk("ct_rom_address", 32'(rom_address), exp_l ? 32'(16'h40 + 4 * nl) : 32'(4 * nf));
      @(posedge clk); #1;
      chk("ct_if_rvalid", 32'(if_rvalid), 32'(!exp_l));
      chk("ct_ld_rvalid", 32'(ld_rvalid), 32'(exp_l));
      if (exp_l) begin
        chk("ct_ld_rdata", ld_rdata, memv(16 + nl));
        nl++;
      end else begin
        chk("ct_if_rdata", if_rdata, memv(nf));
        nf++;
      end
      chk("ct_consec", 32'(dut.consec), exp_l ? 0 : 32'(k % 5 + 1));
    end

    // load alone at 0x10
    @(negedge clk);
    if_req = 1'b0; ld_req = 1'b1; ld_addr = 16'h0010;
    #1;
    chk("lo_ld_gnt", 32'(ld_gnt), 1);
    chk("lo_if_gnt", 32'(if_gnt), 0);
    @(posedge clk); #1;
    chk("lo_ld_rvalid", 32'(ld_rvalid), 1);
    chk("lo_ld_rdata", ld_rdata, memv(4));
    chk("lo_if_rvalid", 32'(if_rvalid), 0);
    chk("lo_consec", 32'(dut.consec), 0);
    @(negedge clk);
    ld_req = 1'b0;

    // address wrap: 0x104 maps to word 1
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0104;
    #1;
    chk("wrap_rom_address", 32'(rom_address), 32'h104);
    @(posedge clk); #1;
    chk("wrap_if_rdata", if_rdata, memv(1));

    // misaligned fetch at 0x6
    @(negedge clk);
    if_addr = 16'h0006;
    #1;
    chk("mis_if_gnt", 32'(if_gnt), 1);
    @(posedge clk); #1;
    chk("mis_if_rvalid", 32'(if_rvalid), 1);
`ifdef ROM_ARBITER_ALIGN_CHECK_EN
    chk("mis_if_err", 32'(if_err), 1);
    chk("mis_if_rdata", if_rdata, 0);
`else
    chk("mis_if_err", 32'(if_err), 0);
    chk("mis_if_rdata", if_rdata, memv(1));
`endif

    // reset pulsed in the cycle after a grant
    @(negedge clk);
    if_addr = 16'h0008;
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 1);
    @(posedge clk); #1;
    chk("rst_if_rvalid_pre", 32'(if_rvalid), 1);
    #2;
    rst_n = 1'b0; if_req = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_if_rvalid", 32'(if_rvalid), 0);
    chk("post_rst_ld_rvalid", 32'(ld_rvalid), 0);
    chk("post_rst_if_rdata", if_rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
